clic_trace_buffer: RTL and testbench

- Parametrised multi-hart trace capture block for the CLIC test environment.
- Collects instruction and interrupt events from NCH channels (one per hart) and timestamps them with a free-running cycle counter.
- Arbitrates the channels round-robin into a single FIFO and streams fixed-format records to a consumer (file writer or DPI sink) over a valid/ready handshake.
- Counts dropped events per channel and flags data loss in the stream.

---
 rtl/clic_trace_buffer.sv | 242 ++++++++++++++++++++++++
 tb/tb_clic_trace_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clic_trace_buffer.sv
// Multi-hart trace capture: per-channel one-entry stages, round-robin arbiter, record FIFO.
// Optional CLIC_TRACE_TS_DELTA_EN: rec_ts_o carries the cycle delta between pushed records.

module clic_trace_stage #(
   parameter int XLEN   = 64,
   parameter int DATA_W = 32,
   parameter int TS_W   = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              acc_i,
   input  logic              gnt_i,
   input  logic [TS_W-1:0]   ts_i,
   input  logic              kind_i,
   input  logic [1:0]        priv_i,
   input  logic [XLEN-1:0]   pc_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              vld_o,
   output logic [TS_W-1:0]   ts_o,
   output logic              kind_o,
   output logic [1:0]        priv_o,
   output logic [XLEN-1:0]   pc_o,
   output logic [DATA_W-1:0] data_o,
   output logic              lost_o,
   output logic [CNT_W-1:0]  cnt_o
);
   logic              vld_q, vld_d, lost_q, lost_d, wr, drop;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TS_W-1:0]   ts_q;
   logic              kind_q;
   logic [1:0]        priv_q;
   logic [XLEN-1:0]   pc_q;
   logic [DATA_W-1:0] data_q;

   // A granted stage empties this cycle, so it can take a new event without a bubble.
   assign drop = acc_i & vld_q & ~gnt_i;
   assign wr   = acc_i & (~vld_q | gnt_i);

   always_comb begin
      vld_d  = (vld_q & ~gnt_i) | wr;
      lost_d = lost_q;
      cnt_d  = cnt_q;
      if (gnt_i) lost_d = 1'b0;
      if (drop) begin
         lost_d = 1'b1;
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      if (clr_i) begin
         lost_d = 1'b0;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q  <= 1'b0;
         lost_q <= 1'b0;
         cnt_q  <= '0;
         ts_q   <= '0;
         kind_q <= 1'b0;
         priv_q <= '0;
         pc_q   <= '0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         lost_q <= lost_d;
         cnt_q  <= cnt_d;
         if (wr) begin
            ts_q   <= ts_i;
            kind_q <= kind_i;
            priv_q <= priv_i;
            pc_q   <= pc_i;
            data_q <= data_i;
         end
      end
   end

   assign vld_o  = vld_q;
   assign ts_o   = ts_q;
   assign kind_o = kind_q;
   assign priv_o = priv_q;
   assign pc_o   = pc_q;
   assign data_o = data_q;
   assign lost_o = lost_q;
   assign cnt_o  = cnt_q;
endmodule

module clic_trace_buffer #(
   parameter int NCH    = 2,
   parameter int XLEN   = 64,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 32,
   parameter int CNT_W  = 16,
   localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  trace_en_i,
   input  logic [3:0]            priv_mask_i,
   input  logic                  clr_i,
   input  logic [NCH-1:0]        ev_valid_i,
   input  logic [NCH-1:0]        ev_kind_i,
   input  logic [2*NCH-1:0]      ev_priv_i,
   input  logic [XLEN*NCH-1:0]   ev_pc_i,
   input  logic [DATA_W*NCH-1:0] ev_data_i,
   output logic                  rec_valid_o,
   input  logic                  rec_ready_i,
   output logic [TS_W-1:0]       rec_ts_o,
   output logic [CW-1:0]         rec_chan_o,
   output logic                  rec_kind_o,
   output logic [1:0]            rec_priv_o,
   output logic [XLEN-1:0]       rec_pc_o,
   output logic [DATA_W-1:0]     rec_data_o,
   output logic                  rec_lost_o,
   output logic [CNT_W*NCH-1:0]  drop_cnt_o,
   output logic                  fifo_full_o
);
   localparam int AW    = $clog2(DEPTH);
   localparam int REC_W = TS_W + CW + 1 + 2 + XLEN + DATA_W + 1;

   logic [TS_W-1:0]                ts_q;
   logic [NCH-1:0]                 acc, gnt, stg_vld, stg_kind, stg_lost;
   logic [NCH-1:0][TS_W-1:0]       stg_ts;
   logic [NCH-1:0][1:0]            stg_priv;
   logic [NCH-1:0][XLEN-1:0]       stg_pc;
   logic [NCH-1:0][DATA_W-1:0]     stg_data;
   logic [NCH-1:0][CNT_W-1:0]      stg_cnt;
   logic [CW-1:0]                  rr_q, rr_d, gnt_idx;
   logic                           gnt_any, push_ok, pop;
   logic [AW:0]                    wp_q, rp_q;
   logic [REC_W-1:0]               mem_q [DEPTH];
   logic [REC_W-1:0]               push_rec;
   logic [TS_W-1:0]                push_ts;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign acc[c] = ev_valid_i[c] & trace_en_i & priv_mask_i[ev_priv_i[2*c +: 2]];
      assign drop_cnt_o[c*CNT_W +: CNT_W] = stg_cnt[c];

      clic_trace_stage #(.XLEN(XLEN), .DATA_W(DATA_W), .TS_W(TS_W), .CNT_W(CNT_W)) u_stage (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .clr_i  (clr_i),
         .acc_i  (acc[c]),
         .gnt_i  (gnt[c]),
         .ts_i   (ts_q),
         .kind_i (ev_kind_i[c]),
         .priv_i (ev_priv_i[2*c +: 2]),
         .pc_i   (ev_pc_i[c*XLEN +: XLEN]),
         .data_i (ev_data_i[c*DATA_W +: DATA_W]),
         .vld_o  (stg_vld[c]),
         .ts_o   (stg_ts[c]),
         .kind_o (stg_kind[c]),
         .priv_o (stg_priv[c]),
         .pc_o   (stg_pc[c]),
         .data_o (stg_data[c]),
         .lost_o (stg_lost[c]),
         .cnt_o  (stg_cnt[c])
      );
   end

   function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NCH) s = s - NCH;
      return CW'(s);
   endfunction

   assign rec_valid_o = (wp_q != rp_q);
   assign fifo_full_o = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign pop         = rec_valid_o & rec_ready_i;
   assign push_ok     = ~fifo_full_o | pop;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (!gnt_any && push_ok && stg_vld[rr_idx(rr_q, i)]) begin
            gnt[rr_idx(rr_q, i)] = 1'b1;
            gnt_idx              = rr_idx(rr_q, i);
            gnt_any              = 1'b1;
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (gnt_any) rr_d = (int'(gnt_idx) == NCH-1) ? '0 : gnt_idx + 1'b1;
   end

`ifdef CLIC_TRACE_TS_DELTA_EN
   logic            first_q;
   logic [TS_W-1:0] dlt_q, dlt_d;

   // dlt_q counts cycles since the last push; the first record keeps its absolute stamp.
   always_comb begin
      dlt_d = (dlt_q == '1) ? dlt_q : dlt_q + 1'b1;
      if (gnt_any) dlt_d = TS_W'(1);
   end
   assign push_ts = first_q ? stg_ts[gnt_idx] : dlt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         first_q <= 1'b1;
         dlt_q   <= '0;
      end else begin
         dlt_q <= dlt_d;
         if (gnt_any) first_q <= 1'b0;
      end
   end
`else
   assign push_ts = stg_ts[gnt_idx];
`endif

   assign push_rec = {push_ts, gnt_idx, stg_kind[gnt_idx], stg_priv[gnt_idx],
                      stg_pc[gnt_idx], stg_data[gnt_idx], stg_lost[gnt_idx]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ts_q <= '0;
         rr_q <= '0;
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         ts_q <= ts_q + 1'b1;
         rr_q <= rr_d;
         if (gnt_any) wp_q <= wp_q + 1'b1;
         if (pop)     rp_q <= rp_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (gnt_any) mem_q[wp_q[AW-1:0]] <= push_rec;
   end

   // Head is masked when empty so an idle stream presents all-zero fields.
   assign {rec_ts_o, rec_chan_o, rec_kind_o, rec_priv_o, rec_pc_o, rec_data_o, rec_lost_o} =
      rec_valid_o ? mem_q[rp_q[AW-1:0]] : '0;
endmodule

// File: tb/tb_clic_trace_buffer.sv
// Randomized + directed bench for clic_trace_buffer against a queue-based reference model.
module tb_clic_trace_buffer;
  localparam int NCH = 2, XLEN = 64, DATA_W = 32, DEPTH = 16, TS_W = 32, CNT_W = 4;

  logic                  clk = 1'b0, rst_n = 1'b0;
  logic                  trace_en, clr, ready;
  logic [3:0]            mask;
  logic [NCH-1:0]        ev_v, ev_k;
  logic [2*NCH-1:0]      ev_p;
  logic [XLEN*NCH-1:0]   ev_pc;
  logic [DATA_W*NCH-1:0] ev_d;
  logic                  rec_valid_o, rec_kind_o, rec_lost_o, fifo_full_o;
  logic [TS_W-1:0]       rec_ts_o;
  logic [0:0]            rec_chan_o;
  logic [1:0]            rec_priv_o;
  logic [XLEN-1:0]       rec_pc_o;
  logic [DATA_W-1:0]     rec_data_o;
  logic [CNT_W*NCH-1:0]  drop_cnt_o;

  clic_trace_buffer #(.NCH(NCH), .XLEN(XLEN), .DATA_W(DATA_W), .DEPTH(DEPTH),
                      .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .trace_en_i(trace_en), .priv_mask_i(mask), .clr_i(clr),
    .ev_valid_i(ev_v), .ev_kind_i(ev_k), .ev_priv_i(ev_p), .ev_pc_i(ev_pc), .ev_data_i(ev_d),
    .rec_valid_o(rec_valid_o), .rec_ready_i(ready), .rec_ts_o(rec_ts_o), .rec_chan_o(rec_chan_o),
    .rec_kind_o(rec_kind_o), .rec_priv_o(rec_priv_o), .rec_pc_o(rec_pc_o), .rec_data_o(rec_data_o),
    .rec_lost_o(rec_lost_o), .drop_cnt_o(drop_cnt_o), .fifo_full_o(fifo_full_o));

  always #5 clk = ~clk;

  int total = 0, bad = 0, seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // reference model: records as queue entries, stages as optional slots
  typedef struct {
    logic [TS_W-1:0]   ts;
    int                chan;
    logic              kind;
    logic [1:0]        priv;
    logic [XLEN-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic              lost;
  } rec_t;

  rec_t            m_fifo[$];
  rec_t            m_stg[NCH];
  bit              m_sv[NCH], m_lost[NCH];
  int              m_drop[NCH];
  int              m_rr;
  logic [TS_W-1:0] m_ts;

  task automatic m_reset();
    m_fifo.delete();
    for (int c = 0; c < NCH; c++) begin
      m_sv[c] = 0; m_lost[c] = 0; m_drop[c] = 0;
    end
    m_rr = 0;
    m_ts = '0;
  endtask

  task automatic m_step();
    bit pop, can;
    int g;
    rec_t r;
    pop = (m_fifo.size() != 0) && ready;
    can = (m_fifo.size() < DEPTH) || pop;
    g = -1;
    if (can)
      for (int i = 0; i < NCH; i++)
        if (g < 0 && m_sv[(m_rr + i) % NCH]) g = (m_rr + i) % NCH;
    if (pop) void'(m_fifo.pop_front());
    if (g >= 0) begin
      r = m_stg[g];
      r.lost = m_lost[g];
      m_fifo.push_back(r);
      m_sv[g] = 0;
      m_lost[g] = 0;
      m_rr = (g + 1) % NCH;
    end
    for (int c = 0; c < NCH; c++) begin
      if (ev_v[c] && trace_en && mask[ev_p[2*c +: 2]]) begin
        if (m_sv[c]) begin
          if (m_drop[c] < (1 << CNT_W) - 1) m_drop[c]++;
          m_lost[c] = 1;
        end else begin
          m_stg[c].ts   = m_ts;
          m_stg[c].chan = c;
          m_stg[c].kind = ev_k[c];
          m_stg[c].priv = ev_p[2*c +: 2];
          m_stg[c].pc   = ev_pc[c*XLEN +: XLEN];
          m_stg[c].data = ev_d[c*DATA_W +: DATA_W];
          m_stg[c].lost = 0;
          m_sv[c] = 1;
        end
      end
    end
    if (clr)
      for (int c = 0; c < NCH; c++) begin
        m_drop[c] = 0; m_lost[c] = 0;
      end
    m_ts = m_ts + 1'b1;
  endtask

  task automatic check_all();
    chk("valid", rec_valid_o, m_fifo.size() != 0);
    chk("full", fifo_full_o, m_fifo.size() == DEPTH);
    if (m_fifo.size() != 0) begin
      chk("ts",   rec_ts_o,   m_fifo[0].ts);
      chk("chan", rec_chan_o, m_fifo[0].chan);
      chk("kind", rec_kind_o, m_fifo[0].kind);
      chk("priv", rec_priv_o, m_fifo[0].priv);
      chk("pc",   rec_pc_o,   m_fifo[0].pc);
      chk("data", rec_data_o, m_fifo[0].data);
      chk("lost", rec_lost_o, m_fifo[0].lost);
    end
    for (int c = 0; c < NCH; c++) chk("drop", drop_cnt_o[c*CNT_W +: CNT_W], m_drop[c]);
  endtask

  task automatic tick();
    if (rec_valid_o && ready) seen++;
    m_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    ev_v = '0; ev_k = '0; ev_p = '0; ev_pc = '0; ev_d = '0;
  endtask

  task automatic set_ev(input int c, input logic kind, input logic [1:0] priv);
    ev_v[c] = 1'b1;
    ev_k[c] = kind;
    ev_p[2*c +: 2] = priv;
    ev_pc[c*XLEN +: XLEN] = {$urandom, $urandom};
    ev_d[c*DATA_W +: DATA_W] = $urandom;
  endtask

  initial begin
    idle();
    trace_en = 1'b1; mask = 4'hF; clr = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rec_valid_o, 0);
    chk("rst_full", fifo_full_o, 0);
    chk("rst_ts", rec_ts_o, 0);
    chk("rst_pc", rec_pc_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    rst_n = 1'b1;
    m_reset();
    check_all();

    // single M-mode event captured at ts=5
    repeat (5) tick();
    set_ev(0, 1'b0, 2'd3);
    tick();
    idle();
    chk("lat_early", rec_valid_o, 0);
    tick();
    chk("lat_valid", rec_valid_o, 1);
    chk("lat_ts", rec_ts_o, 5);
    chk("lat_chan", rec_chan_o, 0);
    chk("lat_priv", rec_priv_o, 3);
    chk("lat_lost", rec_lost_o, 0);
    tick();
    chk("lat_gone", rec_valid_o, 0);

    // both channels every cycle: records + drops must account for all 16 events
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      set_ev(0, 1'b0, 2'd3);
      set_ev(1, 1'b1, 2'd3);
      tick();
    end
    idle();
    repeat (8) tick();
    chk("conserve", seen + drop_cnt_o[3:0] + drop_cnt_o[7:4], 16);

    // back-pressure: fill FIFO + stage, then drain
    clr = 1'b1; tick(); clr = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_ev(0, 1'b0, 2'd3);
      tick();
    end
    idle();
    tick();
    chk("bp_full", fifo_full_o, 1);
    chk("bp_drop0", drop_cnt_o[3:0], 3);
    ready = 1'b1;
    seen = 0;
    repeat (20) tick();
    chk("bp_recs", seen, 17);

    // privilege filter: only M-mode passes, no drops charged
    mask = 4'b1000;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      set_ev(0, 1'b0, 2'd1);
      set_ev(1, 1'b0, 2'd3);
      tick();
    end
    idle();
    repeat (4) tick();
    chk("flt_recs", seen, 10);
    chk("flt_drop0", drop_cnt_o[3:0], 3);
    chk("flt_drop1", drop_cnt_o[7:4], 0);
    mask = 4'hF;

    // saturation, then clear coinciding with a drop
    ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      set_ev(1, 1'b1, 2'd0);
      tick();
    end
    chk("sat_drop1", drop_cnt_o[7:4], 4'hF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle();
    tick();
    chk("clr_drop1", drop_cnt_o[7:4], 0);
    chk("clr_drop0", drop_cnt_o[3:0], 0);
    ready = 1'b1;
    repeat (20) tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 1)) set_ev(c, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        else ev_v[c] = 1'b0;
      end
      trace_en = ($urandom_range(0, 7) != 0);
      mask     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      clr      = ($urandom_range(0, 49) == 0);
      ready    = ($urandom_range(0, 9) < 7);
      tick();
    end
    idle();
    trace_en = 1'b1; mask = 4'hF; clr = 1'b0; ready = 1'b1;
    repeat (25) tick();

    // reset with records buffered
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ev(0, 1'b0, 2'd3);
      tick();
    end
    idle();
    tick();
    chk("pre_rst_valid", rec_valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rec_valid_o, 0);
    chk("mid_rst_full", fifo_full_o, 0);
    chk("mid_rst_drop", drop_cnt_o, 0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    set_ev(0, 1'b1, 2'd3);
    tick();
    idle();
    tick();
    chk("post_rst_valid", rec_valid_o, 1);
    chk("post_rst_ts", rec_ts_o, 0);
    chk("post_rst_kind", rec_kind_o, 1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
